btb_port_arbiter: RTL and testbench
===================================

Name: btb_port_arbiter

Overview:
- Shares one single-ported BTB between two requesters: fetch-stage predict lookups and commit-stage updates.
- Commit updates go into an update FIFO. Predict lookups have priority.
- An anti-starvation counter forces the FIFO to drain.
- Sits between the fetch/commit logic and the BTB model. The BTB model has a one-cycle registered lookup response.

Parameters:
- FIFO_DEPTH, 4, update FIFO entries; power of two, 2..16.
- STARVE_LIMIT, 8, consecutive cycles with the FIFO non-empty and no update issued before an update is forced; 1..255.
- ADDR_W, 64, width of PC and target.

Ports:
- clock  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pred_valid  in  1  fetch lookup request.
- pred_ready  out  1  arbiter accepts the lookup this cycle.
- pred_pc  in  ADDR_W  lookup PC.
- pred_resp_valid  out  1  lookup result valid; one cycle after acceptance.
- pred_resp_hit  out  1  BTB hit.
- pred_resp_target  out  ADDR_W  predicted target.
- pred_resp_is_br  out  1  entry is a conditional branch.
- pred_resp_is_jal  out  1  entry is a jal.
- upd_valid  in  1  commit update request.
- upd_ready  out  1  FIFO not full.
- upd_pc  in  ADDR_W  update PC.
- upd_target  in  ADDR_W  update target.
- upd_is_br  in  1  update is a branch.
- upd_is_jal  in  1  update is a jal.
- btb_req_valid  out  1  lookup issued to the BTB.
- btb_req_pc  out  ADDR_W  lookup PC to the BTB.
- btb_resp_valid  in  1  BTB hit, sampled one cycle after btb_req_valid.
- btb_resp_target  in  ADDR_W  BTB target.
- btb_resp_is_br  in  1  BTB is_br.
- btb_resp_is_jal  in  1  BTB is_jal.
- btb_upd_valid  out  1  update issued to the BTB.
- btb_upd_pc  out  ADDR_W  update PC.
- btb_upd_target  out  ADDR_W  update target.
- btb_upd_is_br  out  1  update is_br.
- btb_upd_is_jal  out  1  update is_jal.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO empty; fifo_count=0; starve counter=0; state=PRED_PRIO.
  - All valid outputs 0; all data outputs 0.
  - upd_ready=0 and pred_ready=0 while in reset.
- Exactly one BTB access per cycle: btb_req_valid and btb_upd_valid are never both 1.
- State PRED_PRIO:
  - pred_ready=1.
  - If pred_valid: issue lookup with btb_req_pc=pred_pc. The starve counter increments if the FIFO is non-empty (saturating at STARVE_LIMIT).
  - If no pred_valid and the FIFO is non-empty: pop the head onto btb_upd_* and clear the starve counter.
  - Counter reaches STARVE_LIMIT → DRAIN.
- State DRAIN:
  - pred_ready=0.
  - Pop exactly one entry to btb_upd_*, clear the counter, return to PRED_PRIO the next cycle.
- FIFO full and pred_valid → forced drain the same as DRAIN, so upd_ready recovers within 2 cycles.
- Lookup response:
  - pred_resp_valid is 1 exactly one cycle after btb_req_valid.
  - pred_resp_* are registered copies of btb_resp_*.
  - pred_resp_hit=btb_resp_valid.
- Update path:
  - upd_ready=!full.
  - Push on upd_valid&&upd_ready.
  - Push and pop in the same cycle: the count is unchanged. Full with a simultaneous pop still accepts the push (upd_ready=!full||pop).
- Pointers wrap modulo FIFO_DEPTH. Count saturates at neither end; overflow and underflow are impossible by construction.
- Updates issue in FIFO order. Updates never issue out of order or get dropped.
- reset_n asserted mid-operation: pending FIFO contents are discarded and pred_resp_valid is cleared immediately.

Optional Feature:
- Macro: BTB_UPDATE_BYPASS_EN.
- Defined:
  - Each lookup compares pred_pc against all valid FIFO entries.
  - On a match, the youngest matching entry overrides the BTB response next cycle: hit=1, with target/is_br/is_jal from that entry.
  - This prevents stale predictions for PCs with pending updates.
- Undefined: no comparison; responses come purely from the BTB.

Test Plan:
- Idle, reset release, single lookup pc=0x8000_0000 with BTB returning hit, target 0x8000_0040 → pred_resp_valid one cycle later, target=0x8000_0040, btb_upd_valid never asserted.
- Three updates with pred_valid=0 → three btb_upd_valid pulses in push order, fifo_count returns to 0, no btb_req_valid.
- One update queued, pred_valid held high continuously, STARVE_LIMIT=8 → after 8 lookup cycles, pred_ready=0 for one cycle and btb_upd_valid=1 with the queued entry.
- Fill FIFO_DEPTH=4 while pred_valid held → upd_ready=0 at count 4, forced drain, upd_ready=1 again within 2 cycles, no entry lost (check order of all pc values).
- Push and pop in the same cycle at count 4 → count stays 4, upd_ready effectively accepts; reset_n pulsed low mid-stream → fifo_count=0 and all valid outputs 0 asynchronously.
- With BTB_UPDATE_BYPASS_EN defined: queue update pc=0x100, target=0x200, then look up pc=0x100 with the BTB missing → pred_resp_hit=1, target=0x200. Without the macro → hit=0.

Source files
------------

// File: rtl/btb_port_arbiter.sv
// Arbitrates a single-ported BTB between fetch lookups and queued commit updates.
// Optional macro BTB_UPDATE_BYPASS_EN: lookups hitting a pending FIFO update return that update.
module btb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned ADDR_W       = 64
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            pred_valid,
  output logic                            pred_ready,
  input  logic [ADDR_W-1:0]               pred_pc,
  output logic                            pred_resp_valid,
  output logic                            pred_resp_hit,
  output logic [ADDR_W-1:0]               pred_resp_target,
  output logic                            pred_resp_is_br,
  output logic                            pred_resp_is_jal,
  input  logic                            upd_valid,
  output logic                            upd_ready,
  input  logic [ADDR_W-1:0]               upd_pc,
  input  logic [ADDR_W-1:0]               upd_target,
  input  logic                            upd_is_br,
  input  logic                            upd_is_jal,
  output logic                            btb_req_valid,
  output logic [ADDR_W-1:0]               btb_req_pc,
  input  logic                            btb_resp_valid,
  input  logic [ADDR_W-1:0]               btb_resp_target,
  input  logic                            btb_resp_is_br,
  input  logic                            btb_resp_is_jal,
  output logic                            btb_upd_valid,
  output logic [ADDR_W-1:0]               btb_upd_pc,
  output logic [ADDR_W-1:0]               btb_upd_target,
  output logic                            btb_upd_is_br,
  output logic                            btb_upd_is_jal,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = 8;

  typedef enum logic {PRED_PRIO, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              is_br;
    logic              is_jal;
  } entry_t;

  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  state_t            state, state_nxt;
  logic              empty, full, pop, push, lookup, resp_pend;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign head  = mem[rd_ptr];

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    pop        = 1'b0;
    lookup     = 1'b0;
    pred_ready = 1'b0;
    case (state)
      PRED_PRIO: begin
        pred_ready = reset_n;
        if (pred_valid && reset_n) begin
          lookup = 1'b1;
          if (empty)
            starve_nxt = '0;
          else if (starve_cnt < SC_W'(STARVE_LIMIT))
            starve_nxt = starve_cnt + SC_W'(1);
          // A full FIFO under lookup pressure drains next cycle so upd_ready recovers quickly
          if (starve_nxt == SC_W'(STARVE_LIMIT) || full)
            state_nxt = DRAIN;
        end else begin
          pop        = !empty;
          starve_nxt = '0;
        end
      end
      DRAIN: begin
        pop        = !empty;
        starve_nxt = '0;
        state_nxt  = PRED_PRIO;
      end
    endcase
  end

  assign upd_ready = reset_n && (!full || pop);
  assign push      = upd_valid && upd_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PRED_PRIO;
      starve_cnt <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      resp_pend  <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      resp_pend  <= lookup;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{pc: upd_pc, target: upd_target, is_br: upd_is_br, is_jal: upd_is_jal};
  end

  assign btb_req_valid  = lookup;
  assign btb_req_pc     = lookup ? pred_pc : '0;
  assign btb_upd_valid  = pop;
  assign btb_upd_pc     = pop ? head.pc     : '0;
  assign btb_upd_target = pop ? head.target : '0;
  assign btb_upd_is_br  = pop && head.is_br;
  assign btb_upd_is_jal = pop && head.is_jal;
  assign fifo_count     = count;
  assign pred_resp_valid = resp_pend;

`ifdef BTB_UPDATE_BYPASS_EN
  logic              byp_hit_c, byp_hit_q;
  entry_t            byp_ent_c;
  logic [ADDR_W-1:0] byp_target_q;
  logic              byp_is_br_q, byp_is_jal_q;

  // Later slots are younger, so the last match wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    byp_hit_c = 1'b0;
    byp_ent_c = '0;
    idx       = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem[idx].pc == pred_pc)) begin
        byp_hit_c = 1'b1;
        byp_ent_c = mem[idx];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byp_hit_q    <= 1'b0;
      byp_target_q <= '0;
      byp_is_br_q  <= 1'b0;
      byp_is_jal_q <= 1'b0;
    end else begin
      byp_hit_q    <= lookup && byp_hit_c;
      byp_target_q <= byp_ent_c.target;
      byp_is_br_q  <= byp_ent_c.is_br;
      byp_is_jal_q <= byp_ent_c.is_jal;
    end
  end

  assign pred_resp_hit    = resp_pend && (byp_hit_q || btb_resp_valid);
  assign pred_resp_target = !resp_pend ? '0 : (byp_hit_q ? byp_target_q : btb_resp_target);
  assign pred_resp_is_br  = resp_pend && (byp_hit_q ? byp_is_br_q  : btb_resp_is_br);
  assign pred_resp_is_jal = resp_pend && (byp_hit_q ? byp_is_jal_q : btb_resp_is_jal);
`else
  // The BTB already registers its response; it is forwarded gated by the pending-lookup flag
  assign pred_resp_hit    = resp_pend && btb_resp_valid;
  assign pred_resp_target = resp_pend ? btb_resp_target : '0;
  assign pred_resp_is_br  = resp_pend && btb_resp_is_br;
  assign pred_resp_is_jal = resp_pend && btb_resp_is_jal;
`endif

endmodule

// File: tb/tb_btb_port_arbiter.sv
// Directed bench for btb_port_arbiter with scoreboard queues for updates and lookup responses.
// Honours BTB_UPDATE_BYPASS_EN when computing expected lookup responses.
module tb_btb_port_arbiter;

`ifdef BTB_UPDATE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        pred_valid, pred_ready;
  logic [63:0] pred_pc;
  logic        pred_resp_valid, pred_resp_hit, pred_resp_is_br, pred_resp_is_jal;
  logic [63:0] pred_resp_target;
  logic        upd_valid, upd_ready, upd_is_br, upd_is_jal;
  logic [63:0] upd_pc, upd_target;
  logic        btb_req_valid;
  logic [63:0] btb_req_pc;
  logic        btb_resp_valid, btb_resp_is_br, btb_resp_is_jal;
  logic [63:0] btb_resp_target;
  logic        btb_upd_valid, btb_upd_is_br, btb_upd_is_jal;
  logic [63:0] btb_upd_pc, btb_upd_target;
  logic [2:0]  fifo_count;

  always #5 clock = ~clock;

  btb_port_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8), .ADDR_W(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_resp_valid(pred_resp_valid), .pred_resp_hit(pred_resp_hit),
    .pred_resp_target(pred_resp_target), .pred_resp_is_br(pred_resp_is_br),
    .pred_resp_is_jal(pred_resp_is_jal),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_is_br(upd_is_br), .upd_is_jal(upd_is_jal),
    .btb_req_valid(btb_req_valid), .btb_req_pc(btb_req_pc),
    .btb_resp_valid(btb_resp_valid), .btb_resp_target(btb_resp_target),
    .btb_resp_is_br(btb_resp_is_br), .btb_resp_is_jal(btb_resp_is_jal),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target),
    .btb_upd_is_br(btb_upd_is_br), .btb_upd_is_jal(btb_upd_is_jal),
    .fifo_count(fifo_count)
  );

  // One-entry BTB model with a registered response
  logic [63:0] mdl_pc, mdl_tgt;
  always @(posedge clock) begin
    btb_resp_valid  <= btb_req_valid && (btb_req_pc == mdl_pc);
    btb_resp_target <= (btb_req_valid && (btb_req_pc == mdl_pc)) ? mdl_tgt : 64'd0;
    btb_resp_is_br  <= btb_req_valid && (btb_req_pc == mdl_pc);
    btb_resp_is_jal <= 1'b0;
  end

  typedef struct packed { logic [63:0] pc; logic [63:0] tgt; logic br; logic jal; } upd_t;
  typedef struct packed { logic hit; logic [63:0] tgt; logic br; logic jal; } rsp_t;
  upd_t upd_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int failures = 0;
  logic obs_req, obs_upd, obs_pred_ready, obs_upd_ready, obs_push, obs_resp_hit;
  logic [63:0] obs_resp_tgt;
  logic [2:0]  obs_count;
  int upd_pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    upd_t e;
    rsp_t r;
    #1;
    chk("one_access", 64'(btb_req_valid & btb_upd_valid), 64'd0);
    chk("fifo_count", 64'(fifo_count), 64'(upd_q.size()));
    obs_resp_hit = pred_resp_hit;
    obs_resp_tgt = pred_resp_target;
    if (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      chk("resp_valid", 64'(pred_resp_valid), 64'd1);
      chk("resp_hit", 64'(pred_resp_hit), 64'(r.hit));
      chk("resp_target", pred_resp_target, r.tgt);
      chk("resp_is_br", 64'(pred_resp_is_br), 64'(r.br));
      chk("resp_is_jal", 64'(pred_resp_is_jal), 64'(r.jal));
    end else begin
      chk("resp_valid_idle", 64'(pred_resp_valid), 64'd0);
    end
    obs_req = btb_req_valid;
    obs_upd = btb_upd_valid;
    obs_pred_ready = pred_ready;
    obs_upd_ready = upd_ready;
    obs_push = upd_valid && upd_ready;
    obs_count = fifo_count;
    if (btb_req_valid) begin
      chk("req_pc", btb_req_pc, pred_pc);
      r.hit = (pred_pc == mdl_pc);
      r.tgt = r.hit ? mdl_tgt : 64'd0;
      r.br  = r.hit;
      r.jal = 1'b0;
      if (BYP) begin
        for (int i = upd_q.size() - 1; i >= 0; i--) begin
          if (upd_q[i].pc == pred_pc) begin
            r.hit = 1'b1;
            r.tgt = upd_q[i].tgt;
            r.br  = upd_q[i].br;
            r.jal = upd_q[i].jal;
            break;
          end
        end
      end
      rsp_q.push_back(r);
    end
    if (btb_upd_valid) begin
      upd_pulses++;
      chk("upd_expected", 64'(upd_q.size() != 0), 64'd1);
      if (upd_q.size() != 0) begin
        e = upd_q.pop_front();
        chk("upd_pc", btb_upd_pc, e.pc);
        chk("upd_target", btb_upd_target, e.tgt);
        chk("upd_is_br", 64'(btb_upd_is_br), 64'(e.br));
        chk("upd_is_jal", 64'(btb_upd_is_jal), 64'(e.jal));
      end
    end
    if (upd_valid && upd_ready) upd_q.push_back({upd_pc, upd_target, upd_is_br, upd_is_jal});
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    pred_valid = 1'b0; pred_pc = 64'd0;
    upd_valid = 1'b0; upd_pc = 64'd0; upd_target = 64'd0; upd_is_br = 1'b0; upd_is_jal = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 64'(fifo_count), 64'd0);
    chk({tag, "_resp_valid"}, 64'(pred_resp_valid), 64'd0);
    chk({tag, "_req_valid"}, 64'(btb_req_valid), 64'd0);
    chk({tag, "_upd_valid"}, 64'(btb_upd_valid), 64'd0);
    chk({tag, "_upd_ready"}, 64'(upd_ready), 64'd0);
    chk({tag, "_pred_ready"}, 64'(pred_ready), 64'd0);
    chk({tag, "_req_pc"}, btb_req_pc, 64'd0);
    chk({tag, "_upd_pc"}, btb_upd_pc, 64'd0);
  endtask

  int lookups, pushed, stall, max_stall;
  logic seen_pp, seen_block;

  initial begin
    idle_inputs();
    mdl_pc = 64'h8000_0000;
    mdl_tgt = 64'h8000_0040;
    // Reset with requests asserted: nothing may be accepted
    pred_valid = 1'b1; upd_valid = 1'b1; pred_pc = 64'h8000_0000; upd_pc = 64'h55;
    #2;
    check_reset_outputs("reset");
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
    tick();

    // Single lookup with a BTB hit
    upd_pulses = 0;
    pred_valid = 1'b1; pred_pc = 64'h8000_0000;
    tick();
    chk("t1_pred_ready", 64'(obs_pred_ready), 64'd1);
    chk("t1_req", 64'(obs_req), 64'd1);
    idle_inputs();
    tick();
    chk("t1_resp_target", obs_resp_tgt, 64'h8000_0040);
    chk("t1_no_upd", 64'(upd_pulses), 64'd0);

    // Three updates with no lookups
    upd_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_pc = 64'h1000 + 64'(i * 4); upd_target = 64'h2000 + 64'(i * 16);
      upd_is_br = i[0]; upd_is_jal = !i[0];
      tick();
      chk("t2_push", 64'(obs_push), 64'd1);
      chk("t2_no_req", 64'(obs_req), 64'd0);
    end
    idle_inputs();
    for (int k = 0; k < 10 && upd_q.size() != 0; k++) begin
      tick();
      chk("t2_no_req", 64'(obs_req), 64'd0);
    end
    chk("t2_drained", 64'(upd_q.size()), 64'd0);
    tick();
    chk("t2_pulses", 64'(upd_pulses), 64'd3);

    // Starvation: one queued update under continuous lookups
    mdl_pc = 64'hdead_0000;
    upd_valid = 1'b1; upd_pc = 64'h3000; upd_target = 64'h3100; upd_is_br = 1'b1; upd_is_jal = 1'b0;
    tick();
    idle_inputs();
    pred_valid = 1'b1;
    lookups = 0;
    obs_upd = 1'b0;
    for (int k = 0; k < 30; k++) begin
      pred_pc = 64'h4000 + 64'(k * 4);
      tick();
      if (obs_upd) break;
      if (obs_req) lookups++;
    end
    chk("t3_forced_upd", 64'(obs_upd), 64'd1);
    chk("t3_lookups", 64'(lookups), 64'd8);
    chk("t3_drain_pred_ready", 64'(obs_pred_ready), 64'd0);
    tick();
    chk("t3_back_pred_ready", 64'(obs_pred_ready), 64'd1);
    idle_inputs();
    tick();

    // Fill the FIFO while lookups stay asserted
    pred_valid = 1'b1;
    pushed = 0; stall = 0; max_stall = 0; seen_pp = 1'b0; seen_block = 1'b0;
    for (int k = 0; k < 60 && pushed < 8; k++) begin
      upd_valid = 1'b1; upd_pc = 64'h5000 + 64'(pushed * 8); upd_target = 64'h6000 + 64'(pushed);
      upd_is_br = 1'b1; upd_is_jal = 1'b0;
      pred_pc = 64'h7000 + 64'(k * 4);
      tick();
      if (obs_push) pushed++;
      if (!obs_upd_ready) stall++; else stall = 0;
      if (stall > max_stall) max_stall = stall;
      if (obs_count == 3'd4 && obs_push && obs_upd) seen_pp = 1'b1;
      if (obs_count == 3'd4 && !obs_upd && !obs_upd_ready) seen_block = 1'b1;
    end
    chk("t4_pushed", 64'(pushed), 64'd8);
    chk("t4_full_blocks", 64'(seen_block), 64'd1);
    chk("t4_full_pushpop", 64'(seen_pp), 64'd1);
    chk("t4_recover_le2", 64'(max_stall <= 2), 64'd1);
    idle_inputs();
    for (int k = 0; k < 20 && upd_q.size() != 0; k++) tick();
    chk("t4_drained", 64'(upd_q.size()), 64'd0);
    tick();

    // Asynchronous reset in the middle of traffic
    pred_valid = 1'b1; pred_pc = 64'h9000;
    upd_valid = 1'b1; upd_pc = 64'h9100; upd_target = 64'h9200;
    tick();
    upd_pc = 64'h9300;
    tick();
    #1;
    chk("t5_pre_count", 64'(fifo_count), 64'd2);
    chk("t5_pre_resp_valid", 64'(pred_resp_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    upd_q.delete();
    rsp_q.delete();
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
    tick();
    tick();

    // Lookup of a PC with a pending update while the BTB misses
    mdl_pc = 64'hdead_0000;
    upd_valid = 1'b1; upd_pc = 64'h100; upd_target = 64'h200; upd_is_br = 1'b0; upd_is_jal = 1'b1;
    tick();
    idle_inputs();
    pred_valid = 1'b1; pred_pc = 64'h100;
    tick();
    idle_inputs();
    tick();
    chk("t6_bypass_hit", 64'(obs_resp_hit), 64'(BYP));
    chk("t6_bypass_target", obs_resp_tgt, BYP ? 64'h200 : 64'd0);
    for (int k = 0; k < 10 && upd_q.size() != 0; k++) tick();
    chk("t6_drained", 64'(upd_q.size()), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
